// File: rtl/kanagawa_pre_fifo_delay_pkg.sv
// Shared types and helpers for the multi-channel pre-FIFO delay block.
package kanagawa_pre_fifo_delay_pkg;

    typedef enum logic {HOLD, RUN} hold_state_t;

    // Width needed to hold values 0..n, never less than one bit.
    function automatic int cnt_width(input int n);
        return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/kanagawa_pre_fifo_delay_chan.sv
// One channel: forward wrreq/data delay, backward ~almost_full delay, optional overflow monitor.
// Monitor built only when KANAGAWA_PRE_FIFO_DELAY_OVF_MON_EN is defined.
module kanagawa_pre_fifo_delay_chan
    import kanagawa_pre_fifo_delay_pkg::*;
#(
    parameter int WIDTH             = 16,
    parameter int FEEDFORWARD_DELAY = 1,
    parameter int FEEDBACK_DELAY    = FEEDFORWARD_DELAY,
    parameter int SLACK             = FEEDFORWARD_DELAY + FEEDBACK_DELAY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wrreq_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             wrreq_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             almost_full_in,
    output logic             not_full_out,
    output logic             overflow_out
);

    if (FEEDFORWARD_DELAY == 0) begin : g_ff_wire
        assign wrreq_out = wrreq_in;
        assign data_out  = data_in;
    end else begin : g_ff_pipe
        logic [FEEDFORWARD_DELAY-1:0] wr_pipe;
        logic [WIDTH-1:0]             data_pipe [FEEDFORWARD_DELAY];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_pipe <= '0;
            end else begin
                wr_pipe[0] <= wrreq_in;
                for (int unsigned i = 1; i < FEEDFORWARD_DELAY; i++)
                    wr_pipe[i] <= wr_pipe[i-1];
            end
        end

        always_ff @(posedge clk) begin
            data_pipe[0] <= data_in;
            for (int unsigned i = 1; i < FEEDFORWARD_DELAY; i++)
                data_pipe[i] <= data_pipe[i-1];
        end

        assign wrreq_out = wr_pipe[FEEDFORWARD_DELAY-1];
        assign data_out  = data_pipe[FEEDFORWARD_DELAY-1];
    end

    // Inverted sense so the reset value (0) reads as "full" at the producer.
    if (FEEDBACK_DELAY == 0) begin : g_fb_wire
        assign not_full_out = ~almost_full_in;
    end else begin : g_fb_pipe
        logic [FEEDBACK_DELAY-1:0] ok_pipe;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ok_pipe <= '0;
            end else begin
                ok_pipe[0] <= ~almost_full_in;
                for (int unsigned i = 1; i < FEEDBACK_DELAY; i++)
                    ok_pipe[i] <= ok_pipe[i-1];
            end
        end

        assign not_full_out = ok_pipe[FEEDBACK_DELAY-1];
    end

`ifdef KANAGAWA_PRE_FIFO_DELAY_OVF_MON_EN
    localparam int CW = cnt_width(SLACK + 1);
    localparam logic [CW-1:0] SLACK_C = CW'(SLACK);

    logic [CW-1:0] cnt;
    logic          ovf;

    // Clear wins over increment; count saturates at SLACK+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (!almost_full_in) begin
            cnt <= '0;
        end else if (wrreq_out) begin
            if (cnt >= SLACK_C)
                ovf <= 1'b1;
            if (cnt <= SLACK_C)
                cnt <= cnt + 1'b1;
        end
    end

    assign overflow_out = ovf;
`else
    assign overflow_out = 1'b0;
`endif

endmodule

// File: rtl/kanagawa_pre_fifo_delay_multi.sv
// N-channel registered delay between producers and write-side FIFOs, with a shared post-reset hold.
// Optional overflow monitor: KANAGAWA_PRE_FIFO_DELAY_OVF_MON_EN.
module kanagawa_pre_fifo_delay_multi
    import kanagawa_pre_fifo_delay_pkg::*;
#(
    parameter int NUM_CHANNELS      = 1,
    parameter int WIDTH             = 16,
    parameter int FEEDFORWARD_DELAY = 1,
    parameter int FEEDBACK_DELAY    = FEEDFORWARD_DELAY,
    parameter int RESET_HOLD_CYCLES = 4,
    parameter int SLACK             = FEEDFORWARD_DELAY + FEEDBACK_DELAY
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CHANNELS-1:0]       wrreq_in,
    input  logic [NUM_CHANNELS*WIDTH-1:0] data_in,
    output logic [NUM_CHANNELS-1:0]       almost_full_out,
    output logic [NUM_CHANNELS-1:0]       wrreq_out,
    output logic [NUM_CHANNELS*WIDTH-1:0] data_out,
    input  logic [NUM_CHANNELS-1:0]       almost_full_in,
    output logic [NUM_CHANNELS-1:0]       overflow_out
);

    localparam int HCW = cnt_width(RESET_HOLD_CYCLES);
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(RESET_HOLD_CYCLES);

    hold_state_t    state, state_next;
    logic [HCW-1:0] hold_cnt, hold_cnt_next;
    logic           hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HOLD;
            hold_cnt <= HOLD_LOAD;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
        end
    end

    // Leaving on the edge that would bring the count to 0 keeps hold high for exactly RESET_HOLD_CYCLES edges.
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        case (state)
            HOLD: begin
                if (hold_cnt <= HCW'(1)) begin
                    state_next    = RUN;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt - 1'b1;
                end
            end
            RUN:     state_next = RUN;
            default: state_next = HOLD;
        endcase
    end

    always_comb begin
        hold = (state == HOLD);
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        logic not_full;

        kanagawa_pre_fifo_delay_chan #(
            .WIDTH             (WIDTH),
            .FEEDFORWARD_DELAY (FEEDFORWARD_DELAY),
            .FEEDBACK_DELAY    (FEEDBACK_DELAY),
            .SLACK             (SLACK)
        ) u_chan (
            .clk            (clk),
            .rst            (rst),
            .wrreq_in       (wrreq_in[c]),
            .data_in        (data_in[c*WIDTH +: WIDTH]),
            .wrreq_out      (wrreq_out[c]),
            .data_out       (data_out[c*WIDTH +: WIDTH]),
            .almost_full_in (almost_full_in[c]),
            .not_full_out   (not_full),
            .overflow_out   (overflow_out[c])
        );

        assign almost_full_out[c] = ~not_full | hold;
    end

endmodule

// File: tb/tb_kanagawa_pre_fifo_delay_multi.sv
// Scoreboard bench: stimulus pushes expected writes, a negedge monitor pops and compares them.
module tb_kanagawa_pre_fifo_delay_multi;

`ifdef KANAGAWA_PRE_FIFO_DELAY_OVF_MON_EN
    localparam logic MON = 1'b1;
`else
    localparam logic MON = 1'b0;
`endif
    localparam int FF_A = 3;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [1:0]  wrreq_in_a, af_out_a, wrreq_out_a, af_in_a, ovf_a;
    logic [31:0] data_in_a, data_out_a;
    logic [1:0]  wrreq_in_b, af_out_b, wrreq_out_b, af_in_b, ovf_b;
    logic [31:0] data_in_b, data_out_b;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    kanagawa_pre_fifo_delay_multi #(
        .NUM_CHANNELS(2), .WIDTH(16), .FEEDFORWARD_DELAY(FF_A), .FEEDBACK_DELAY(2),
        .RESET_HOLD_CYCLES(4), .SLACK(3)
    ) dut_a (
        .clk(clk), .rst(rst_a), .wrreq_in(wrreq_in_a), .data_in(data_in_a),
        .almost_full_out(af_out_a), .wrreq_out(wrreq_out_a), .data_out(data_out_a),
        .almost_full_in(af_in_a), .overflow_out(ovf_a)
    );

    kanagawa_pre_fifo_delay_multi #(
        .NUM_CHANNELS(2), .WIDTH(16), .FEEDFORWARD_DELAY(0), .FEEDBACK_DELAY(0),
        .RESET_HOLD_CYCLES(0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .wrreq_in(wrreq_in_b), .data_in(data_in_b),
        .almost_full_out(af_out_b), .wrreq_out(wrreq_out_b), .data_out(data_out_b),
        .almost_full_in(af_in_b), .overflow_out(ovf_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_chan(input int c);
        exp_t e;
        if ((c == 0 && q0.size() == 0) || (c == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL spurious_wr_ch%0d actual wrreq_out=1 required 0 (cyc %0d)", c, cyc);
            return;
        end
        if (c == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("wr_data_ch%0d", c), {16'h0, data_out_a[c*16 +: 16]}, {16'h0, e.data});
        chk($sformatf("wr_cycle_ch%0d", c), cyc, e.cyc);
    endtask

    always @(negedge clk) begin
        if (wrreq_out_a[0] === 1'b1) mon_chan(0);
        if (wrreq_out_a[1] === 1'b1) mon_chan(1);
    end

    task automatic issue(input logic [1:0] wr, input logic [15:0] d0, input logic [15:0] d1);
        @(posedge clk);
        #1;
        wrreq_in_a = wr;
        data_in_a  = {d1, d0};
        if (wr[0]) q0.push_back('{d0, cyc + FF_A});
        if (wr[1]) q1.push_back('{d1, cyc + FF_A});
    endtask

    task automatic idle_a();
        @(posedge clk);
        #1;
        wrreq_in_a = 2'b00;
    endtask

    task automatic to_neg(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    // Called right after rst_a falls: hold must last exactly four edges.
    task automatic hold_check(input string tag);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("%s_hold_%0d", tag, k), {30'h0, af_out_a}, 32'h3);
        end
        @(negedge clk);
        chk($sformatf("%s_run", tag), {30'h0, af_out_a}, 32'h0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int p;
        rst_a = 1'b1; rst_b = 1'b1;
        wrreq_in_a = '0; data_in_a = '0; af_in_a = '0;
        wrreq_in_b = '0; data_in_b = '0; af_in_b = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wrreq", {30'h0, wrreq_out_a}, 32'h0);
        chk("rst_af", {30'h0, af_out_a}, 32'h3);
        chk("rst_ovf", {30'h0, ovf_a}, 32'h0);
        chk("rst_af_b", {30'h0, af_out_b}, 32'h3);

        // Post-reset hold
        @(posedge clk);
        #1 rst_a = 1'b0;
        hold_check("t1");

        // Forward latency, back-to-back, both channels
        issue(2'b01, 16'hA5A5, 16'h0000);
        issue(2'b11, 16'h1234, 16'hBEEF);
        issue(2'b01, 16'h5678, 16'h0000);
        idle_a();
        repeat (6) @(negedge clk);
        chk("t2_drained", q0.size() + q1.size(), 0);

        // Feedback latency on channel 1
        @(posedge clk);
        #1 af_in_a = 2'b10;
        p = cyc;
        to_neg(p + 1);
        chk("t3_fb_pre", {30'h0, af_out_a}, 32'h0);
        to_neg(p + 2);
        chk("t3_fb_rise", {30'h0, af_out_a}, 32'h2);
        @(posedge clk);
        #1 af_in_a = 2'b00;
        to_neg(p + 4);
        chk("t3_fb_hold", {30'h0, af_out_a}, 32'h2);
        to_neg(p + 5);
        chk("t3_fb_fall", {30'h0, af_out_a}, 32'h0);

        // Overflow monitor: 3 writes within slack, 4th overflows
        issue(2'b01, 16'hC001, 16'h0000);
        af_in_a = 2'b01;
        p = cyc;
        issue(2'b01, 16'hC002, 16'h0000);
        issue(2'b01, 16'hC003, 16'h0000);
        issue(2'b01, 16'hC004, 16'h0000);
        idle_a();
        to_neg(p + 6);
        chk("t5_ovf_within", {30'h0, ovf_a}, 32'h0);
        to_neg(p + 7);
        chk("t5_ovf_set", {30'h0, ovf_a}, {31'h0, MON});
        @(posedge clk);
        #1 af_in_a = 2'b00;
        repeat (3) @(negedge clk);
        chk("t5_ovf_sticky", {30'h0, ovf_a}, {31'h0, MON});

        // Reset with three writes in flight
        issue(2'b01, 16'hD001, 16'h0000);
        issue(2'b01, 16'hD002, 16'h0000);
        issue(2'b01, 16'hD003, 16'h0000);
        idle_a();
        chk("t4_pre_rst", {30'h0, wrreq_out_a}, 32'h1);
        #1 rst_a = 1'b1;
        #1;
        chk("t4_async_clr", {30'h0, wrreq_out_a}, 32'h0);
        chk("t4_af_forced", {30'h0, af_out_a}, 32'h3);
        chk("t4_ovf_clr", {30'h0, ovf_a}, 32'h0);
        q0.delete();
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
        hold_check("t4");
        repeat (6) @(negedge clk);
        chk("t4_drained", q0.size() + q1.size(), 0);

        // Combinational paths
        @(posedge clk);
        #1;
        af_in_b = 2'b01;
        rst_b   = 1'b0;
        #1 chk("t6_hold_pre_edge", {30'h0, af_out_b}, 32'h3);
        @(posedge clk);
        #1 chk("t6_af_run", {30'h0, af_out_b}, 32'h1);
        wrreq_in_b = 2'b10;
        data_in_b  = 32'h2222_1111;
        #1;
        chk("t6_wr_comb", {30'h0, wrreq_out_b}, 32'h2);
        chk("t6_data_comb", data_out_b, 32'h2222_1111);
        af_in_b    = 2'b10;
        wrreq_in_b = 2'b01;
        #1;
        chk("t6_af_comb", {30'h0, af_out_b}, 32'h2);
        chk("t6_wr_comb2", {30'h0, wrreq_out_b}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
